// File: rtl/ahb_single_manager.sv
// AHB-Lite manager: client req/resp handshake -> pipelined SINGLE NONSEQ transfers (AHB_MGR_ALIGN_CHECK_EN traps misaligned requests).
// Latency: accept at edge N, address phase N+1, data phase N+2, RespValid N+3; one response per cycle when back-to-back.
// Backpressure: ReqReady drops on wait states with AP occupied and during ERROR; responses cannot be stalled.
module ahb_single_manager #(
    parameter int XLEN    = 64,
    parameter int PA_BITS = 56
) (
    input  logic                 HCLK,
    input  logic                 HRESETn,
    input  logic                 ReqValid,
    output logic                 ReqReady,
    input  logic                 ReqWrite,
    input  logic [PA_BITS-1:0]   ReqAddr,
    input  logic [2:0]           ReqSize,
    input  logic [XLEN-1:0]      ReqWData,
    input  logic [XLEN/8-1:0]    ReqStrb,
    output logic                 RespValid,
    output logic [XLEN-1:0]      RespRData,
    output logic                 RespErr,
    output logic [PA_BITS-1:0]   HADDR,
    output logic                 HWRITE,
    output logic [2:0]           HSIZE,
    output logic [2:0]           HBURST,
    output logic [1:0]           HTRANS,
    output logic [XLEN-1:0]      HWDATA,
    output logic [XLEN/8-1:0]    HWSTRB,
    input  logic [XLEN-1:0]      HRDATA,
    input  logic                 HREADY,
    input  logic                 HRESP
);
    localparam int SW = XLEN / 8;

    typedef enum logic {NORMAL = 1'b0, ERRHOLD = 1'b1} fsm_e;

    fsm_e                fsm_q, fsm_d;
    logic                ap_vld_q, ap_vld_d;
    logic                ap_local_q, ap_local_d;
    logic [PA_BITS-1:0]  ap_addr_q, ap_addr_d;
    logic                ap_write_q, ap_write_d;
    logic [2:0]          ap_size_q, ap_size_d;
    logic [XLEN-1:0]     ap_wdata_q, ap_wdata_d;
    logic [SW-1:0]       ap_strb_q, ap_strb_d;
    logic                dp_vld_q, dp_vld_d;
    logic                dp_local_q, dp_local_d;
    logic                dp_write_q, dp_write_d;
    logic [XLEN-1:0]     dp_wdata_q, dp_wdata_d;
    logic [SW-1:0]       dp_strb_q, dp_strb_d;
    logic                resp_vld_q, resp_vld_d;
    logic [XLEN-1:0]     resp_rdata_q, resp_rdata_d;
    logic                resp_err_q, resp_err_d;

    logic normal, hresp_eff, accept, advance, req_local;

`ifdef AHB_MGR_ALIGN_CHECK_EN
    logic [PA_BITS-1:0] align_mask;
    assign align_mask = ~({PA_BITS{1'b1}} << ReqSize);
    assign req_local  = |(ReqAddr & align_mask);
`else
    assign req_local  = 1'b0;
`endif

    // HRESP only matters while a real transfer occupies the data phase.
    assign normal    = (fsm_q == NORMAL);
    assign hresp_eff = HRESP & dp_vld_q & ~dp_local_q;
    assign ReqReady  = normal & ~hresp_eff & (~ap_vld_q | HREADY);
    assign accept    = ReqValid & ReqReady;
    assign advance   = normal & ~hresp_eff & HREADY;

    always_comb begin
        fsm_d      = fsm_q;
        ap_vld_d   = ap_vld_q;
        ap_local_d = ap_local_q;
        ap_addr_d  = ap_addr_q;
        ap_write_d = ap_write_q;
        ap_size_d  = ap_size_q;
        ap_wdata_d = ap_wdata_q;
        ap_strb_d  = ap_strb_q;
        dp_vld_d   = dp_vld_q;
        dp_local_d = dp_local_q;
        dp_write_d = dp_write_q;
        dp_wdata_d = dp_wdata_q;
        dp_strb_d  = dp_strb_q;

        if (advance) begin
            dp_vld_d   = ap_vld_q;
            dp_local_d = ap_local_q;
            dp_write_d = ap_write_q;
            dp_wdata_d = ap_wdata_q;
            dp_strb_d  = ap_strb_q;
            ap_vld_d   = 1'b0;
        end else if (HREADY) begin
            // Data phase retires on an error or out of ERRHOLD; AP stays put.
            dp_vld_d = 1'b0;
        end

        if (accept) begin
            ap_vld_d   = 1'b1;
            ap_local_d = req_local;
            ap_addr_d  = ReqAddr;
            ap_write_d = ReqWrite;
            ap_size_d  = ReqSize;
            ap_wdata_d = ReqWData;
            ap_strb_d  = ReqStrb;
        end

        if (normal && hresp_eff && !HREADY) begin
            fsm_d = ERRHOLD;
        end else if (!normal && HREADY) begin
            fsm_d = NORMAL;
        end

        resp_vld_d   = dp_vld_q & HREADY;
        resp_rdata_d = '0;
        resp_err_d   = 1'b0;
        if (resp_vld_d) begin
            if (dp_local_q) begin
                resp_err_d = 1'b1;
            end else begin
                resp_err_d = HRESP;
                if (!dp_write_q) resp_rdata_d = HRDATA;
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            fsm_q        <= NORMAL;
            ap_vld_q     <= 1'b0;
            ap_local_q   <= 1'b0;
            ap_addr_q    <= '0;
            ap_write_q   <= 1'b0;
            ap_size_q    <= '0;
            ap_wdata_q   <= '0;
            ap_strb_q    <= '0;
            dp_vld_q     <= 1'b0;
            dp_local_q   <= 1'b0;
            dp_write_q   <= 1'b0;
            dp_wdata_q   <= '0;
            dp_strb_q    <= '0;
            resp_vld_q   <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            fsm_q        <= fsm_d;
            ap_vld_q     <= ap_vld_d;
            ap_local_q   <= ap_local_d;
            ap_addr_q    <= ap_addr_d;
            ap_write_q   <= ap_write_d;
            ap_size_q    <= ap_size_d;
            ap_wdata_q   <= ap_wdata_d;
            ap_strb_q    <= ap_strb_d;
            dp_vld_q     <= dp_vld_d;
            dp_local_q   <= dp_local_d;
            dp_write_q   <= dp_write_d;
            dp_wdata_q   <= dp_wdata_d;
            dp_strb_q    <= dp_strb_d;
            resp_vld_q   <= resp_vld_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign HTRANS    = (ap_vld_q && normal && !ap_local_q) ? 2'b10 : 2'b00;
    assign HADDR     = ap_addr_q;
    assign HWRITE    = ap_write_q;
    assign HSIZE     = ap_size_q;
    assign HBURST    = 3'b000;
    assign HWDATA    = dp_wdata_q;
    assign HWSTRB    = dp_strb_q;
    assign RespValid = resp_vld_q;
    assign RespRData = resp_rdata_q;
    assign RespErr   = resp_err_q;
endmodule

// File: tb/tb_ahb_single_manager.sv
// Directed bench for ahb_single_manager: scoreboard of expected responses plus a small AHB subordinate memory.
`timescale 1ns/1ps
module tb_ahb_single_manager;
    localparam int XLEN    = 64;
    localparam int PA_BITS = 56;
    localparam int SW      = XLEN / 8;

    logic                HCLK = 1'b0;
    logic                HRESETn;
    logic                ReqValid, ReqReady, ReqWrite;
    logic [PA_BITS-1:0]  ReqAddr;
    logic [2:0]          ReqSize;
    logic [XLEN-1:0]     ReqWData;
    logic [SW-1:0]       ReqStrb;
    logic                RespValid, RespErr;
    logic [XLEN-1:0]     RespRData;
    logic [PA_BITS-1:0]  HADDR;
    logic                HWRITE;
    logic [2:0]          HSIZE, HBURST;
    logic [1:0]          HTRANS;
    logic [XLEN-1:0]     HWDATA, HRDATA;
    logic [SW-1:0]       HWSTRB;
    logic                HREADY, HRESP;

    ahb_single_manager #(.XLEN(XLEN), .PA_BITS(PA_BITS)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqWrite(ReqWrite), .ReqAddr(ReqAddr),
        .ReqSize(ReqSize), .ReqWData(ReqWData), .ReqStrb(ReqStrb),
        .RespValid(RespValid), .RespRData(RespRData), .RespErr(RespErr),
        .HADDR(HADDR), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HTRANS(HTRANS),
        .HWDATA(HWDATA), .HWSTRB(HWSTRB), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
    );

    always #5 HCLK = ~HCLK;

    // Subordinate: 16 x 64-bit words, word i preset to 0x0101..01 * i; HRDATA is zero during an error.
    logic [63:0] mem [16];
    logic        sub_vld, sub_wr;
    logic [3:0]  sub_idx;
    always @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            sub_vld <= 1'b0;
            sub_wr  <= 1'b0;
            sub_idx <= '0;
            for (int i = 0; i < 16; i++) mem[i] <= 64'h0101_0101_0101_0101 * 64'(i);
        end else if (HREADY) begin
            if (sub_vld && sub_wr) mem[sub_idx] <= HWDATA;
            sub_vld <= (HTRANS == 2'b10);
            sub_wr  <= HWRITE;
            sub_idx <= HADDR[6:3];
        end
    end
    assign HRDATA = (sub_vld && !sub_wr && !HRESP) ? mem[sub_idx] : '0;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic [63:0] rdata;
        logic        err;
    } exp_t;
    exp_t sb[$];
    int   run_len = 0;
    int   max_run = 0;

    always @(negedge HCLK) begin
        if (RespValid) begin
            run_len++;
            if (run_len > max_run) max_run = run_len;
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_resp: got RespValid=1 with rdata 0x%0h, expected no response", RespRData);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("resp_rdata", RespRData, e.rdata);
                chk("resp_err", 64'(RespErr), 64'(e.err));
            end
        end else begin
            run_len = 0;
        end
    end

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic req(input logic wr, input logic [PA_BITS-1:0] a, input logic [63:0] wd);
        ReqValid = 1'b1;
        ReqWrite = wr;
        ReqAddr  = a;
        ReqSize  = 3'd3;
        ReqWData = wd;
        ReqStrb  = 8'hFF;
    endtask

    task automatic accept(input string name, input logic [63:0] er, input logic ee);
        exp_t e;
        #1;
        chk(name, 64'(ReqReady), 64'd1);
        e.rdata = er;
        e.err   = ee;
        sb.push_back(e);
    endtask

    logic [PA_BITS-1:0] t2_addr [4] = '{56'h8000_0020, 56'h8000_0028, 56'h8000_0030, 56'h8000_0038};
    logic [63:0]        t2_exp  [4] = '{64'h0404_0404_0404_0404, 64'h0505_0505_0505_0505,
                                        64'h0606_0606_0606_0606, 64'h0707_0707_0707_0707};

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected end of test");
        $fatal(1);
    end

    initial begin
        HRESETn = 1'b0; ReqValid = 1'b0; ReqWrite = 1'b0; ReqAddr = '0; ReqSize = '0;
        ReqWData = '0; ReqStrb = '0; HREADY = 1'b1; HRESP = 1'b0;
        repeat (2) tick();
        chk("rst_htrans", 64'(HTRANS), 64'd0);
        chk("rst_resp_vld", 64'(RespValid), 64'd0);
        chk("rst_haddr", 64'(HADDR), 64'd0);
        chk("rst_hburst", 64'(HBURST), 64'd0);
        HRESETn = 1'b1;
        tick();

        // Zero-wait write then read of the same word
        req(1'b1, 56'h8000_0010, 64'h1122_3344_5566_7788);
        accept("t1_acc_wr", 64'd0, 1'b0);
        tick();
        req(1'b0, 56'h8000_0010, 64'd0);
        accept("t1_acc_rd", 64'h1122_3344_5566_7788, 1'b0);
        chk("t1_htrans_c1", 64'(HTRANS), 64'd2);
        chk("t1_hwrite_c1", 64'(HWRITE), 64'd1);
        chk("t1_haddr_c1", 64'(HADDR), 64'h8000_0010);
        chk("t1_hsize_c1", 64'(HSIZE), 64'd3);
        tick();
        ReqValid = 1'b0;
        chk("t1_htrans_c2", 64'(HTRANS), 64'd2);
        chk("t1_hwrite_c2", 64'(HWRITE), 64'd0);
        chk("t1_hwdata_c2", HWDATA, 64'h1122_3344_5566_7788);
        chk("t1_hwstrb_c2", 64'(HWSTRB), 64'hFF);
        tick();
        chk("t1_wr_resp_c3", 64'(RespValid), 64'd1);
        tick();
        chk("t1_rd_resp_c4", 64'(RespValid), 64'd1);
        chk("t1_rd_data_c4", RespRData, 64'h1122_3344_5566_7788);
        repeat (2) tick();

        // Four back-to-back reads
        max_run = 0;
        for (int k = 0; k < 4; k++) begin
            req(1'b0, t2_addr[k], 64'd0);
            accept("t2_acc", t2_exp[k], 1'b0);
            tick();
            chk("t2_htrans", 64'(HTRANS), 64'd2);
            chk("t2_haddr", 64'(HADDR), 64'(t2_addr[k]));
        end
        ReqValid = 1'b0;
        repeat (4) tick();
        chk("t2_consecutive_resp", 64'(max_run), 64'd4);

        // Three wait states on a read data phase with a write held in AP
        req(1'b0, 56'h8000_0028, 64'd0);
        accept("t3_acc_rd", 64'h0505_0505_0505_0505, 1'b0);
        tick();
        req(1'b1, 56'h8000_0040, 64'hDEAD_BEEF_CAFE_F00D);
        accept("t3_acc_wr", 64'd0, 1'b0);
        tick();
        ReqValid = 1'b0;
        HREADY   = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("t3_wait_ready", 64'(ReqReady), 64'd0);
            chk("t3_wait_haddr", 64'(HADDR), 64'h8000_0040);
            chk("t3_wait_hwrite", 64'(HWRITE), 64'd1);
            chk("t3_wait_htrans", 64'(HTRANS), 64'd2);
            chk("t3_wait_no_resp", 64'(RespValid), 64'd0);
            tick();
        end
        HREADY = 1'b1;
        tick();
        chk("t3_wr_hwdata", HWDATA, 64'hDEAD_BEEF_CAFE_F00D);
        chk("t3_ap_empty", 64'(HTRANS), 64'd0);
        repeat (3) tick();

        // Two-cycle ERROR on a read, write pending in AP
        req(1'b0, 56'h8000_0030, 64'd0);
        accept("t4_acc_rd", 64'd0, 1'b1);
        tick();
        req(1'b1, 56'h8000_0048, 64'h0123_4567_89AB_CDEF);
        accept("t4_acc_wr", 64'd0, 1'b0);
        tick();
        ReqValid = 1'b0;
        HREADY   = 1'b0;
        HRESP    = 1'b1;
        #1;
        chk("t4_err1_ready", 64'(ReqReady), 64'd0);
        chk("t4_err1_htrans", 64'(HTRANS), 64'd2);
        tick();
        HREADY = 1'b1;
        #1;
        chk("t4_err2_htrans_idle", 64'(HTRANS), 64'd0);
        chk("t4_err2_ready", 64'(ReqReady), 64'd0);
        tick();
        HRESP = 1'b0;
        #1;
        chk("t4_reissue_htrans", 64'(HTRANS), 64'd2);
        chk("t4_reissue_haddr", 64'(HADDR), 64'h8000_0048);
        chk("t4_err_resp_vld", 64'(RespValid), 64'd1);
        chk("t4_err_resp_err", 64'(RespErr), 64'd1);
        tick();
        chk("t4_wr_hwdata", HWDATA, 64'h0123_4567_89AB_CDEF);
        repeat (2) tick();
        req(1'b0, 56'h8000_0048, 64'd0);
        accept("t4_acc_readback", 64'h0123_4567_89AB_CDEF, 1'b0);
        tick();
        ReqValid = 1'b0;
        repeat (4) tick();

        // Reset during a data phase drops the request
        req(1'b0, 56'h8000_0038, 64'd0);
        #1;
        chk("t5_acc", 64'(ReqReady), 64'd1);
        tick();
        ReqValid = 1'b0;
        tick();
        HRESETn = 1'b0;
        #1;
        chk("t5_rst_htrans", 64'(HTRANS), 64'd0);
        chk("t5_rst_resp_vld", 64'(RespValid), 64'd0);
        chk("t5_rst_haddr", 64'(HADDR), 64'd0);
        repeat (2) tick();
        HRESETn = 1'b1;
        repeat (5) tick();
        chk("t5_post_htrans", 64'(HTRANS), 64'd0);

        // Doubleword read at a 4-byte-aligned address
        req(1'b0, 56'h8000_0004, 64'd0);
`ifdef AHB_MGR_ALIGN_CHECK_EN
        accept("t6_acc", 64'd0, 1'b1);
        tick();
        chk("t6_local_htrans", 64'(HTRANS), 64'd0);
`else
        accept("t6_acc", 64'd0, 1'b0);
        tick();
        chk("t6_htrans", 64'(HTRANS), 64'd2);
        chk("t6_haddr", 64'(HADDR), 64'h8000_0004);
`endif
        ReqValid = 1'b0;
        repeat (5) tick();
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
